// File: rtl/nebula_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nebula_pkg
//  Description : Shared NoC types for the Nebula network interface: field
//                widths and the noc_flit_t flit record.
//  Revision    : 1.0 - initial release
// ============================================================================
package nebula_pkg;

    localparam int COORD_WIDTH     = 4;
    localparam int VC_ID_WIDTH     = 2;
    localparam int QOS_WIDTH       = 2;
    localparam int PACKET_ID_WIDTH = 4;
    localparam int SEQ_NUM_WIDTH   = 4;
    localparam int PAYLOAD_WIDTH   = 16;

    typedef enum logic [1:0] {
        FLIT_HEAD   = 2'd0,
        FLIT_BODY   = 2'd1,
        FLIT_TAIL   = 2'd2,
        FLIT_SINGLE = 2'd3
    } flit_type_e;

    typedef struct packed {
        flit_type_e                 flit_type;
        logic [COORD_WIDTH-1:0]     src_x;
        logic [COORD_WIDTH-1:0]     src_y;
        logic [VC_ID_WIDTH-1:0]     vc_id;
        logic [QOS_WIDTH-1:0]       qos;
        logic [PACKET_ID_WIDTH-1:0] packet_id;
        logic [SEQ_NUM_WIDTH-1:0]   seq_num;
        logic [PAYLOAD_WIDTH-1:0]   payload;
    } noc_flit_t;

endpackage
`default_nettype wire

// File: rtl/nebula_packet_reassembler_if.sv
`default_nettype none
// ============================================================================
//  Module      : nebula_packet_reassembler_if
//  Description : Bundle for the packet reassembler: flit input handshake,
//                packet output handshake with metadata/payload, error pulses
//                and busy.
//                slave  modport : the reassembler side.
//                master modport : the producer/consumer side.
//                Optional err_seq exists only when NEBULA_REASM_SEQ_CHECK_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nebula_packet_reassembler_if #(
    parameter int MAX_FLITS = 4
) ();
    import nebula_pkg::*;

    localparam int PFW     = PAYLOAD_WIDTH;
    localparam int c_CNT_W = $clog2(MAX_FLITS + 1);

    logic                       flit_valid;
    noc_flit_t                  flit_in;
    logic                       flit_ready;

    logic                       pkt_valid;
    logic                       pkt_ready;
    logic [COORD_WIDTH-1:0]     pkt_src_x;
    logic [COORD_WIDTH-1:0]     pkt_src_y;
    logic [VC_ID_WIDTH-1:0]     pkt_vc_id;
    logic [QOS_WIDTH-1:0]       pkt_qos;
    logic [PACKET_ID_WIDTH-1:0] pkt_id;
    logic [SEQ_NUM_WIDTH-1:0]   pkt_seq;
    logic [MAX_FLITS*PFW-1:0]   pkt_payload;
    logic [c_CNT_W-1:0]         pkt_nflits;

    logic                       err_orphan;
    logic                       err_trunc;
    logic                       err_mismatch;
    logic                       err_overflow;
    logic                       busy;
`ifdef NEBULA_REASM_SEQ_CHECK_EN
    logic                       err_seq;
`endif

    modport slave (
        input  flit_valid, flit_in, pkt_ready,
        output flit_ready, pkt_valid, pkt_src_x, pkt_src_y, pkt_vc_id,
               pkt_qos, pkt_id, pkt_seq, pkt_payload, pkt_nflits,
               err_orphan, err_trunc, err_mismatch, err_overflow,
`ifdef NEBULA_REASM_SEQ_CHECK_EN
               err_seq,
`endif
               busy
    );

    modport master (
        output flit_valid, flit_in, pkt_ready,
        input  flit_ready, pkt_valid, pkt_src_x, pkt_src_y, pkt_vc_id,
               pkt_qos, pkt_id, pkt_seq, pkt_payload, pkt_nflits,
               err_orphan, err_trunc, err_mismatch, err_overflow,
`ifdef NEBULA_REASM_SEQ_CHECK_EN
               err_seq,
`endif
               busy
    );

endinterface
`default_nettype wire

// File: rtl/nebula_packet_reassembler.sv
`default_nettype none
// ============================================================================
//  Module      : nebula_packet_reassembler
//  Description : Destination-NI packet reassembler for one VC. Collects
//                HEAD/BODY/TAIL (or SINGLE) flits, checks framing and
//                presents one packet record (metadata from HEAD/SINGLE,
//                payload flit k at [k*PFW +: PFW]). Malformed packets are
//                dropped and flagged with a one-cycle error pulse.
//  Ports       : clk, rst (sync, active-high)
//                bus.slave : flit_valid/flit_in/flit_ready (input stream),
//                            pkt_valid/pkt_ready + pkt_* (packet output),
//                            err_orphan/trunc/mismatch/overflow, busy
//  Config      : NEBULA_REASM_SEQ_CHECK_EN adds err_seq, pulsed when a
//                delivered packet's seq is not previous delivered seq + 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module nebula_packet_reassembler #(
    parameter int MAX_FLITS = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    nebula_packet_reassembler_if.slave  bus
);
    import nebula_pkg::*;

    localparam int PFW     = PAYLOAD_WIDTH;
    localparam int c_CNT_W = $clog2(MAX_FLITS + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DELIVER = 2'd2,
        S_DROP    = 2'd3
    } state_e;

    state_e                     r_state;
    state_e                     w_next;

    logic [COORD_WIDTH-1:0]     r_src_x;
    logic [COORD_WIDTH-1:0]     r_src_y;
    logic [VC_ID_WIDTH-1:0]     r_vc_id;
    logic [QOS_WIDTH-1:0]       r_qos;
    logic [PACKET_ID_WIDTH-1:0] r_id;
    logic [SEQ_NUM_WIDTH-1:0]   r_seq;
    logic [MAX_FLITS*PFW-1:0]   r_payload;
    logic [c_CNT_W-1:0]         r_count;
    logic [c_CNT_W-1:0]         r_nflits;

    logic r_err_orphan, r_err_trunc, r_err_mismatch, r_err_overflow;

    logic w_accept;
    logic w_id_match;
    logic w_full;
    logic w_start;
    logic w_append;
    logic w_tail_ok;
    logic w_clear;
    logic w_e_orphan, w_e_trunc, w_e_mismatch, w_e_overflow;

    assign w_accept   = bus.flit_valid && (r_state != S_DELIVER);
    assign w_id_match = (bus.flit_in.packet_id == r_id);
    // Every slot already holds a flit: any further BODY/TAIL overflows.
    assign w_full     = (r_count == c_CNT_W'(MAX_FLITS));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and datapath strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next       = r_state;
        w_start      = 1'b0;
        w_append     = 1'b0;
        w_tail_ok    = 1'b0;
        w_clear      = 1'b0;
        w_e_orphan   = 1'b0;
        w_e_trunc    = 1'b0;
        w_e_mismatch = 1'b0;
        w_e_overflow = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (bus.flit_in.flit_type)
                        FLIT_HEAD: begin
                            w_start = 1'b1;
                            w_next  = S_COLLECT;
                        end
                        FLIT_SINGLE: begin
                            w_start = 1'b1;
                            w_next  = S_DELIVER;
                        end
                        default: w_e_orphan = 1'b1;
                    endcase
                end
            end

            S_COLLECT: begin
                if (w_accept) begin
                    case (bus.flit_in.flit_type)
                        FLIT_HEAD, FLIT_SINGLE: begin
                            w_e_trunc = 1'b1;
                            w_start   = 1'b1;
                            w_next    = (bus.flit_in.flit_type == FLIT_SINGLE) ?
                                        S_DELIVER : S_COLLECT;
                        end
                        FLIT_BODY: begin
                            if (!w_id_match) begin
                                w_e_mismatch = 1'b1;
                                w_next       = S_DROP;
                            end else if (w_full) begin
                                w_e_overflow = 1'b1;
                                w_next       = S_DROP;
                            end else begin
                                w_append = 1'b1;
                            end
                        end
                        default: begin
                            // TAIL closes the packet either way, so error
                            // cases return straight to IDLE.
                            if (!w_id_match) begin
                                w_e_mismatch = 1'b1;
                                w_next       = S_IDLE;
                            end else if (w_full) begin
                                w_e_overflow = 1'b1;
                                w_next       = S_IDLE;
                            end else begin
                                w_append  = 1'b1;
                                w_tail_ok = 1'b1;
                                w_next    = S_DELIVER;
                            end
                        end
                    endcase
                end
            end

            S_DROP: begin
                if (w_accept) begin
                    case (bus.flit_in.flit_type)
                        FLIT_HEAD: begin
                            w_e_trunc = 1'b1;
                            w_start   = 1'b1;
                            w_next    = S_COLLECT;
                        end
                        FLIT_SINGLE: begin
                            w_e_trunc = 1'b1;
                            w_start   = 1'b1;
                            w_next    = S_DELIVER;
                        end
                        FLIT_TAIL: w_next = S_IDLE;
                        default:   w_next = S_DROP;
                    endcase
                end
            end

            default: begin
                if (bus.pkt_ready) begin
                    w_clear = 1'b1;
                    w_next  = S_IDLE;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Packet buffer, metadata and error pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src_x        <= '0;
            r_src_y        <= '0;
            r_vc_id        <= '0;
            r_qos          <= '0;
            r_id           <= '0;
            r_seq          <= '0;
            r_payload      <= '0;
            r_count        <= '0;
            r_nflits       <= '0;
            r_err_orphan   <= 1'b0;
            r_err_trunc    <= 1'b0;
            r_err_mismatch <= 1'b0;
            r_err_overflow <= 1'b0;
        end else begin
            r_err_orphan   <= w_e_orphan;
            r_err_trunc    <= w_e_trunc;
            r_err_mismatch <= w_e_mismatch;
            r_err_overflow <= w_e_overflow;

            if (w_start) begin
                // A new packet wipes any leftovers of an abandoned one so
                // unused upper slots always read as zero.
                r_src_x            <= bus.flit_in.src_x;
                r_src_y            <= bus.flit_in.src_y;
                r_vc_id            <= bus.flit_in.vc_id;
                r_qos              <= bus.flit_in.qos;
                r_id               <= bus.flit_in.packet_id;
                r_seq              <= bus.flit_in.seq_num;
                r_payload          <= '0;
                r_payload[PFW-1:0] <= bus.flit_in.payload;
                r_count            <= c_CNT_W'(1);
                r_nflits           <= c_CNT_W'(1);
            end else if (w_append) begin
                r_payload[int'(r_count)*PFW +: PFW] <= bus.flit_in.payload;
                r_count <= r_count + c_CNT_W'(1);
                if (w_tail_ok) begin
                    r_nflits <= r_count + c_CNT_W'(1);
                end
            end else if (w_clear) begin
                r_src_x   <= '0;
                r_src_y   <= '0;
                r_vc_id   <= '0;
                r_qos     <= '0;
                r_id      <= '0;
                r_seq     <= '0;
                r_payload <= '0;
                r_count   <= '0;
                r_nflits  <= '0;
            end
        end
    end

`ifdef NEBULA_REASM_SEQ_CHECK_EN
    // ------------------------------------------------------------------
    // Sequence continuity across delivered packets
    // ------------------------------------------------------------------
    logic                     r_have_prev;
    logic [SEQ_NUM_WIDTH-1:0] r_prev_seq;
    logic                     r_err_seq;
    logic                     w_enter_deliver;
    logic [SEQ_NUM_WIDTH-1:0] w_deliver_seq;
    logic [SEQ_NUM_WIDTH-1:0] w_seq_expect;

    assign w_enter_deliver = (w_next == S_DELIVER) && (r_state != S_DELIVER);
    // SINGLE carries its own seq; for a TAIL the HEAD's seq is already held.
    assign w_deliver_seq   = (bus.flit_in.flit_type == FLIT_SINGLE) ?
                             bus.flit_in.seq_num : r_seq;
    assign w_seq_expect    = r_prev_seq + SEQ_NUM_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_have_prev <= 1'b0;
            r_prev_seq  <= '0;
            r_err_seq   <= 1'b0;
        end else begin
            r_err_seq <= 1'b0;
            if (w_enter_deliver) begin
                r_err_seq   <= r_have_prev && (w_deliver_seq != w_seq_expect);
                r_prev_seq  <= w_deliver_seq;
                r_have_prev <= 1'b1;
            end
        end
    end

    assign bus.err_seq = r_err_seq;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.flit_ready   = (r_state != S_DELIVER);
    assign bus.pkt_valid    = (r_state == S_DELIVER);
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.pkt_src_x    = r_src_x;
    assign bus.pkt_src_y    = r_src_y;
    assign bus.pkt_vc_id    = r_vc_id;
    assign bus.pkt_qos      = r_qos;
    assign bus.pkt_id       = r_id;
    assign bus.pkt_seq      = r_seq;
    assign bus.pkt_payload  = r_payload;
    assign bus.pkt_nflits   = r_nflits;
    assign bus.err_orphan   = r_err_orphan;
    assign bus.err_trunc    = r_err_trunc;
    assign bus.err_mismatch = r_err_mismatch;
    assign bus.err_overflow = r_err_overflow;

endmodule
`default_nettype wire

// File: tb/tb_nebula_packet_reassembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nebula_packet_reassembler
//  Description : Directed bench for nebula_packet_reassembler. The stimulus
//                thread pushes expected packets and expected error pulses
//                into queues; a negedge monitor pops and compares them
//                whenever the DUT hands over a packet or raises an error.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nebula_packet_reassembler;
    import nebula_pkg::*;

    localparam int MAX_FLITS = 4;
    localparam int PFW       = PAYLOAD_WIDTH;
    localparam int PW        = MAX_FLITS * PFW;
    localparam int CW        = $clog2(MAX_FLITS + 1);

    localparam logic [4:0] E_ORPH = 5'b10000;
    localparam logic [4:0] E_TRNC = 5'b01000;
    localparam logic [4:0] E_MISM = 5'b00100;
    localparam logic [4:0] E_OVFL = 5'b00010;
    localparam logic [4:0] E_SEQ  = 5'b00001;

    typedef struct packed {
        logic [COORD_WIDTH-1:0]     sx;
        logic [COORD_WIDTH-1:0]     sy;
        logic [VC_ID_WIDTH-1:0]     vc;
        logic [QOS_WIDTH-1:0]       qos;
        logic [PACKET_ID_WIDTH-1:0] id;
        logic [SEQ_NUM_WIDTH-1:0]   seq;
        logic [PW-1:0]              payload;
        logic [CW-1:0]              nflits;
    } exp_pkt_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    exp_pkt_t   pkt_q[$];
    logic [4:0] err_q[$];

    nebula_packet_reassembler_if #(.MAX_FLITS(MAX_FLITS)) bus ();

    nebula_packet_reassembler #(.MAX_FLITS(MAX_FLITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic noc_flit_t mk(input flit_type_e t, input int sx, input int sy,
                                     input int vc, input int qos, input int id,
                                     input int seq, input int pl);
        noc_flit_t f;
        f.flit_type = t;
        f.src_x     = COORD_WIDTH'(sx);
        f.src_y     = COORD_WIDTH'(sy);
        f.vc_id     = VC_ID_WIDTH'(vc);
        f.qos       = QOS_WIDTH'(qos);
        f.packet_id = PACKET_ID_WIDTH'(id);
        f.seq_num   = SEQ_NUM_WIDTH'(seq);
        f.payload   = PFW'(pl);
        return f;
    endfunction

    function automatic logic [PW-1:0] pack(input int n, input int d0, input int d1,
                                           input int d2, input int d3);
        logic [PW-1:0] v;
        int d[4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        v = '0;
        for (int k = 0; k < n; k++) v[k*PFW +: PFW] = PFW'(d[k]);
        return v;
    endfunction

    task automatic push_pkt(input int sx, input int sy, input int vc, input int qos,
                            input int id, input int seq, input logic [PW-1:0] pl,
                            input int n);
        exp_pkt_t e;
        e.sx = COORD_WIDTH'(sx);  e.sy = COORD_WIDTH'(sy);
        e.vc = VC_ID_WIDTH'(vc);  e.qos = QOS_WIDTH'(qos);
        e.id = PACKET_ID_WIDTH'(id); e.seq = SEQ_NUM_WIDTH'(seq);
        e.payload = pl; e.nflits = CW'(n);
        pkt_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Entered just after a posedge; leaves just after the accepting posedge.
    task automatic send(input noc_flit_t f);
        int n;
        n = 0;
        bus.flit_in    = f;
        bus.flit_valid = 1'b1;
        @(negedge clk);
        while (!bus.flit_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!bus.flit_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: flit_ready=%b expected 1", bus.flit_ready);
        end
        @(posedge clk); #1;
        bus.flit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic [4:0] code;
        exp_pkt_t   e;
        if (!rst) begin
            code = {bus.err_orphan, bus.err_trunc, bus.err_mismatch, bus.err_overflow, 1'b0};
`ifdef NEBULA_REASM_SEQ_CHECK_EN
            code[0] = bus.err_seq;
`endif
            if (code != 5'b0) begin
                checks++;
                if (err_q.size() == 0) begin
                    errors++;
                    $display("FAIL err_unexpected: got %b expected none", code);
                end else begin
                    logic [4:0] x;
                    x = err_q.pop_front();
                    if (code !== x) begin
                        errors++;
                        $display("FAIL err_code: got %b expected %b", code, x);
                    end
                end
            end
            if (bus.pkt_valid && bus.pkt_ready) begin
                if (pkt_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pkt_unexpected: got id %h expected no packet", bus.pkt_id);
                end else begin
                    e = pkt_q.pop_front();
                    check("pkt_meta",
                          64'({bus.pkt_src_x, bus.pkt_src_y, bus.pkt_vc_id, bus.pkt_qos,
                               bus.pkt_id, bus.pkt_seq}),
                          64'({e.sx, e.sy, e.vc, e.qos, e.id, e.seq}));
                    check("pkt_payload", 64'(bus.pkt_payload), 64'(e.payload));
                    check("pkt_nflits", 64'(bus.pkt_nflits), 64'(e.nflits));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [PW-1:0] hold_pl;
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.flit_valid = 1'b0;
        bus.flit_in    = '0;
        bus.pkt_ready  = 1'b1;
        idle(3);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_flit_ready", 64'(bus.flit_ready), 64'd1);
        check("rst_pkt_valid", 64'(bus.pkt_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_fields", 64'({bus.pkt_src_x, bus.pkt_src_y, bus.pkt_id, bus.pkt_nflits}), 64'd0);
        check("rst_payload", 64'(bus.pkt_payload), 64'd0);
        @(posedge clk); #1;

        // SINGLE held by back-pressure
        bus.pkt_ready = 1'b0;
        push_pkt(1, 2, 0, 1, 3, 0, pack(1, 'hA5, 0, 0, 0), 1);
        send(mk(FLIT_SINGLE, 1, 2, 0, 1, 3, 0, 'hA5));
        @(negedge clk);
        check("single_latency_valid", 64'(bus.pkt_valid), 64'd1);
        hold_pl = bus.pkt_payload;
        check("single_payload_now", 64'(hold_pl), 64'h00A5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(bus.pkt_valid), 64'd1);
            check("hold_flit_ready", 64'(bus.flit_ready), 64'd0);
            check("hold_payload", 64'(bus.pkt_payload), 64'(hold_pl));
        end
        @(posedge clk); #1;
        bus.pkt_ready = 1'b1;
        idle(2);
        check("deliver_clears_payload", 64'(bus.pkt_payload), 64'd0);

        // HEAD/BODY/TAIL; routing fields of BODY/TAIL must be ignored
        push_pkt(2, 3, 1, 2, 7, 1, pack(3, 'h1, 'h2, 'h3, 0), 3);
        send(mk(FLIT_HEAD, 2, 3, 1, 2, 7, 1, 'h1));
        send(mk(FLIT_BODY, 9, 9, 3, 3, 7, 9, 'h2));
        send(mk(FLIT_TAIL, 8, 8, 2, 0, 7, 8, 'h3));
        idle(2);

        // Orphan TAIL, then a normal SINGLE
        err_q.push_back(E_ORPH);
        send(mk(FLIT_TAIL, 0, 0, 0, 0, 2, 0, 'h77));
        @(negedge clk);
        check("orphan_no_valid", 64'(bus.pkt_valid), 64'd0);
        @(posedge clk); #1;
        push_pkt(4, 5, 2, 3, 6, 2, pack(1, 'hC3C3, 0, 0, 0), 1);
        send(mk(FLIT_SINGLE, 4, 5, 2, 3, 6, 2, 'hC3C3));
        idle(2);

        // ID mismatch: BODY mismatch -> DROP, drain until TAIL
        err_q.push_back(E_MISM);
        send(mk(FLIT_HEAD, 1, 1, 0, 0, 4, 9, 'h10));
        send(mk(FLIT_BODY, 1, 1, 0, 0, 5, 9, 'h11));
        send(mk(FLIT_BODY, 1, 1, 0, 0, 5, 9, 'h12));
        send(mk(FLIT_TAIL, 1, 1, 0, 0, 5, 9, 'h13));
        idle(1);
        check("mismatch_idle", 64'(bus.busy), 64'd0);

        // DROP left by a SINGLE: truncation, SINGLE delivered
        err_q.push_back(E_MISM);
        err_q.push_back(E_TRNC);
        send(mk(FLIT_HEAD, 1, 1, 0, 0, 1, 9, 'h20));
        send(mk(FLIT_BODY, 1, 1, 0, 0, 2, 9, 'h21));
        push_pkt(7, 1, 3, 0, 3, 3, pack(1, 'hBEEF, 0, 0, 0), 1);
        send(mk(FLIT_SINGLE, 7, 1, 3, 0, 3, 3, 'hBEEF));
        idle(2);

        // Largest legal packet
        push_pkt(6, 6, 1, 1, 8, 4, pack(4, 'hA1, 'hA2, 'hA3, 'hA4), 4);
        send(mk(FLIT_HEAD, 6, 6, 1, 1, 8, 4, 'hA1));
        send(mk(FLIT_BODY, 0, 0, 0, 0, 8, 0, 'hA2));
        send(mk(FLIT_BODY, 0, 0, 0, 0, 8, 0, 'hA3));
        send(mk(FLIT_TAIL, 0, 0, 0, 0, 8, 0, 'hA4));
        idle(2);

        // Overflow on 4th BODY, then drained by TAIL
        err_q.push_back(E_OVFL);
        send(mk(FLIT_HEAD, 2, 2, 0, 0, 9, 9, 'h1));
        for (int i = 0; i < 4; i++) send(mk(FLIT_BODY, 2, 2, 0, 0, 9, 9, 'h2 + i));
        send(mk(FLIT_TAIL, 2, 2, 0, 0, 9, 9, 'h9));
        idle(1);
        check("overflow_idle", 64'(bus.busy), 64'd0);

        // Overflow on a TAIL that would be flit MAX_FLITS+1
        err_q.push_back(E_OVFL);
        send(mk(FLIT_HEAD, 2, 2, 0, 0, 12, 9, 'h1));
        for (int i = 0; i < 3; i++) send(mk(FLIT_BODY, 2, 2, 0, 0, 12, 9, 'h2 + i));
        send(mk(FLIT_TAIL, 2, 2, 0, 0, 12, 9, 'h9));
        idle(1);
        check("tail_overflow_idle", 64'(bus.busy), 64'd0);

        // HEAD then HEAD: truncation, second packet delivered
        err_q.push_back(E_TRNC);
        send(mk(FLIT_HEAD, 3, 3, 0, 0, 10, 9, 'hDEAD));
        push_pkt(5, 6, 1, 2, 11, 5, pack(3, 'h11, 'h22, 'h33, 0), 3);
        send(mk(FLIT_HEAD, 5, 6, 1, 2, 11, 5, 'h11));
        send(mk(FLIT_BODY, 0, 0, 0, 0, 11, 0, 'h22));
        send(mk(FLIT_TAIL, 0, 0, 0, 0, 11, 0, 'h33));
        idle(2);

        // Reset mid-COLLECT discards everything silently
        send(mk(FLIT_HEAD, 4, 4, 0, 0, 13, 9, 'h44));
        send(mk(FLIT_BODY, 4, 4, 0, 0, 13, 9, 'h45));
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_valid", 64'(bus.pkt_valid), 64'd0);
        check("midrst_payload", 64'(bus.pkt_payload), 64'd0);
        check("midrst_nflits", 64'(bus.pkt_nflits), 64'd0);
        check("midrst_flit_ready", 64'(bus.flit_ready), 64'd1);
        @(posedge clk); #1;

        // Sequence continuity: 4 (first after reset), 5, 6, 8
        push_pkt(1, 1, 0, 0, 1, 4, pack(1, 'h4, 0, 0, 0), 1);
        send(mk(FLIT_SINGLE, 1, 1, 0, 0, 1, 4, 'h4));
        idle(1);
        push_pkt(1, 1, 0, 0, 1, 5, pack(1, 'h5, 0, 0, 0), 1);
        send(mk(FLIT_SINGLE, 1, 1, 0, 0, 1, 5, 'h5));
        idle(1);
        push_pkt(1, 1, 0, 0, 2, 6, pack(2, 'h6, 'h66, 0, 0), 2);
        send(mk(FLIT_HEAD, 1, 1, 0, 0, 2, 6, 'h6));
        send(mk(FLIT_TAIL, 0, 0, 0, 0, 2, 0, 'h66));
        idle(1);
`ifdef NEBULA_REASM_SEQ_CHECK_EN
        err_q.push_back(E_SEQ);
`endif
        push_pkt(1, 1, 0, 0, 3, 8, pack(1, 'h8, 0, 0, 0), 1);
        send(mk(FLIT_SINGLE, 1, 1, 0, 0, 3, 8, 'h8));
        idle(4);

        check("pkt_queue_drained", 64'(pkt_q.size()), 64'd0);
        check("err_queue_drained", 64'(err_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
